// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR LFSR generator/checker pair: tap table,
// checker state encoding and the maximal-period helper.
package lfsr_pkg;

  localparam int MIN_BITS = 3;
  localparam int MAX_BITS = 12;

  // Maximal-length XNOR taps by width; bit (t-1) is set for tap t.
  localparam logic [MAX_BITS-1:0] TAP_MASK [MIN_BITS:MAX_BITS] = '{
    12'h006,  // 3 : 3,2
    12'h00C,  // 4 : 4,3
    12'h014,  // 5 : 5,3
    12'h030,  // 6 : 6,5
    12'h060,  // 7 : 7,6
    12'h0B8,  // 8 : 8,6,5,4
    12'h110,  // 9 : 9,5
    12'h240,  // 10: 10,7
    12'h500,  // 11: 11,9
    12'h829   // 12: 12,6,4,1
  };

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [MAX_BITS-1:0] period_len(input int n);
    period_len = MAX_BITS'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational step of the XNOR LFSR; shared by generator and checker.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 5
) (
  input  logic [NUM_BITS-1:0] i_State,
  output logic [NUM_BITS-1:0] o_Next
);

  localparam logic [MAX_BITS-1:0] MASK_FULL = TAP_MASK[NUM_BITS];
  localparam logic [NUM_BITS-1:0] MASK      = MASK_FULL[NUM_BITS-1:0];

  assign o_Next = {i_State[NUM_BITS-2:0], ~^(i_State & MASK)};

endmodule

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the XNOR LFSR state stream.
// Optional period check is built when LFSR_PERIOD_CHECK_EN is defined.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 5,
  parameter int SYNC_LEN = 4,
  parameter int LOSS_LEN = 3,
  parameter int CNT_W    = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  input  logic                i_LFSR_Done,
  input  logic                i_Resync,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [CNT_W-1:0]    o_Err_Count,
  output logic                o_Period_Ok,
  output logic                o_Period_Err
);

  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int MISS_W  = $clog2(LOSS_LEN + 1);
  localparam logic [MATCH_W-1:0] SYNC_TGT = MATCH_W'(SYNC_LEN);
  localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_LEN);

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] model_q, model_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                lock_entry;

  logic [NUM_BITS-1:0] samp_next, model_next;
  logic                samp_ones, samp_hit;

  lfsr_step #(.NUM_BITS(NUM_BITS)) u_step_samp (
    .i_State (i_LFSR_Data),
    .o_Next  (samp_next)
  );

  lfsr_step #(.NUM_BITS(NUM_BITS)) u_step_model (
    .i_State (model_q),
    .o_Next  (model_next)
  );

  assign samp_ones = &i_LFSR_Data;
  assign samp_hit  = (i_LFSR_Data == model_q);

  always_comb begin
    state_d    = state_q;
    model_d    = model_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    lock_entry = 1'b0;
    if (i_Resync) begin
      state_d = ST_HUNT;
      match_d = '0;
      miss_d  = '0;
    end else if (i_Enable) begin
      case (state_q)
        ST_HUNT: begin
          if (!samp_ones) begin
            model_d = samp_next;
            match_d = '0;
            miss_d  = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (samp_hit) begin
            match_d = match_q + 1'b1;
            model_d = model_next;
            if (match_d == SYNC_TGT) begin
              state_d    = ST_LOCKED;
              miss_d     = '0;
              lock_entry = 1'b1;
            end
          end else begin
            // Reseed from the stream; mismatches here are not errors yet.
            model_d = samp_next;
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Advance from the model so one bad sample costs one error only.
          model_d = model_next;
          if (samp_hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            miss_d = miss_q + 1'b1;
            if (miss_d == LOSS_TGT) begin
              state_d = ST_HUNT;
              miss_d  = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= ST_HUNT;
      model_q   <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      model_q   <= model_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_Locked    = (state_q == ST_LOCKED);
  assign o_Error     = err_q;
  assign o_Err_Count = err_cnt_q;

`ifdef LFSR_PERIOD_CHECK_EN
  localparam logic [MAX_BITS-1:0] PER_FULL = period_len(NUM_BITS);
  localparam logic [NUM_BITS-1:0] PERIOD   = PER_FULL[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] per_cnt_q, per_cnt_d;
  logic                aligned_q, aligned_d;
  logic                pok_q, pok_d;
  logic                perr_q, perr_d;

  always_comb begin
    per_cnt_d = per_cnt_q;
    aligned_d = aligned_q;
    pok_d     = 1'b0;
    perr_d    = 1'b0;
    if (lock_entry) begin
      per_cnt_d = '0;
      aligned_d = 1'b0;
    end else if (!i_Resync && i_Enable && state_q == ST_LOCKED) begin
      if (i_LFSR_Done) begin
        // The first period end after lock only establishes the phase.
        per_cnt_d = NUM_BITS'(1);
        aligned_d = 1'b1;
        if (aligned_q) begin
          pok_d  = (per_cnt_q == PERIOD);
          perr_d = (per_cnt_q != PERIOD);
        end
      end else begin
        per_cnt_d = per_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      per_cnt_q <= '0;
      aligned_q <= 1'b0;
      pok_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      aligned_q <= aligned_d;
      pok_q     <= pok_d;
      perr_q    <= perr_d;
    end
  end

  assign o_Period_Ok  = pok_q;
  assign o_Period_Err = perr_q;
`else
  logic unused_period;
  assign unused_period = i_LFSR_Done ^ lock_entry;
  assign o_Period_Ok   = 1'b0;
  assign o_Period_Err  = 1'b0;
`endif

endmodule
